// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file bank.
// Holds the geometry constants and the pointer-operation encoding that are used by
// reg_file_bank and its per-pair storage, reg_pair.
package reg_file_pkg;

  localparam int NUM_PAIRS = 16;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    PTR_NOP = 2'b00,
    PTR_INC = 2'b01,
    PTR_DEC = 2'b10,
    PTR_RSV = 2'b11
  } ptr_op_t;

endpackage

// File: rtl/reg_pair.sv
// One 16-bit register pair (two bytes) with byte writes, pointer inc/dec,
// write-vs-pointer conflict resolution and a registered zero flag.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   wen[1:0]          - byte write enables (bit 0 low byte, bit 1 high byte)
//   din               - write data for both bytes
//   ren[1:0]          - byte read enables
//   op, sel           - pointer operation and "this pair is targeted"
//   dout              - gated read data (combinational)
//   wrap, conflict    - registered one-cycle pulses
//   zero              - registered flag: pair held 0x0000 after the previous edge
module reg_pair
  import reg_file_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          wen,
  input  logic [2*BYTE_W-1:0] din,
  input  logic [1:0]          ren,
  input  ptr_op_t             op,
  input  logic                sel,
  output logic [2*BYTE_W-1:0] dout,
  output logic                wrap,
  output logic                conflict,
  output logic                zero
);

  localparam int PW = 2 * BYTE_W;

  logic [PW-1:0] val_r;
  logic [PW-1:0] val_next;
  logic          wrap_next;
  logic          conflict_next;
  logic          ptr_active;

  assign ptr_active = sel && ((op == PTR_INC) || (op == PTR_DEC));

  // Next-state of the pair: a write to either byte wins and drops the pointer op.
  always_comb begin
    val_next      = val_r;
    wrap_next     = 1'b0;
    conflict_next = 1'b0;
    if (wen != 2'b00) begin
      if (wen[0]) begin
        val_next[BYTE_W-1:0] = din[BYTE_W-1:0];
      end else begin
        val_next[BYTE_W-1:0] = val_r[BYTE_W-1:0];
      end
      if (wen[1]) begin
        val_next[PW-1:BYTE_W] = din[PW-1:BYTE_W];
      end else begin
        val_next[PW-1:BYTE_W] = val_r[PW-1:BYTE_W];
      end
      conflict_next = ptr_active;
    end else if (ptr_active) begin
      // Whole-pair arithmetic so carry/borrow crosses the byte boundary.
      case (op)
        PTR_INC: begin
          val_next  = val_r + PW'(1);
          wrap_next = (val_r == {PW{1'b1}});
        end
        PTR_DEC: begin
          val_next  = val_r - PW'(1);
          wrap_next = (val_r == {PW{1'b0}});
        end
        default: begin
          val_next  = val_r;
          wrap_next = 1'b0;
        end
      endcase
    end else begin
      val_next = val_r;
    end
  end

  // Storage, pulse registers and the zero flag (which trails storage by one edge).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_r    <= {PW{1'b0}};
      wrap     <= 1'b0;
      conflict <= 1'b0;
      zero     <= 1'b1;
    end else begin
      val_r    <= val_next;
      wrap     <= wrap_next;
      conflict <= conflict_next;
      zero     <= (val_r == {PW{1'b0}});
    end
  end

  // Reads are forced to zero while reset is held so nothing leaks during reset.
  assign dout[BYTE_W-1:0]  = (ren[0] && !reset) ? val_r[BYTE_W-1:0]  : {BYTE_W{1'b0}};
  assign dout[PW-1:BYTE_W] = (ren[1] && !reset) ? val_r[PW-1:BYTE_W] : {BYTE_W{1'b0}};

endmodule

// File: rtl/reg_file_bank.sv
// Bank of NUM_PAIRS 16-bit register pairs with per-byte write/read enables and a
// single per-cycle pointer increment/decrement on one addressed pair.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   wen, ren       - per-byte enables, bit 2p = pair p low byte, 2p+1 = high byte
//   data_in        - write data, pair p at [16p+15:16p]
//   data_out       - combinational gated read data, same packing
//   ptr_op         - 00 none, 01 inc, 10 dec, 11 treated as none
//   ptr_addr       - pair targeted by ptr_op
//   ptr_wrap       - one-cycle pulse after an inc/dec wraps
//   ptr_conflict   - one-cycle pulse after a pointer op is dropped by a write
//   pair_zero      - registered per-pair zero flags
module reg_file_bank #(
  parameter int NUM_PAIRS = reg_file_pkg::NUM_PAIRS,
  parameter int BYTE_W    = reg_file_pkg::BYTE_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [2*NUM_PAIRS-1:0]          wen,
  input  logic [2*NUM_PAIRS*BYTE_W-1:0]   data_in,
  input  logic [2*NUM_PAIRS-1:0]          ren,
  output logic [2*NUM_PAIRS*BYTE_W-1:0]   data_out,
  input  logic [1:0]                      ptr_op,
  input  logic [3:0]                      ptr_addr,
  output logic                            ptr_wrap,
  output logic                            ptr_conflict,
  output logic [NUM_PAIRS-1:0]            pair_zero
);

  import reg_file_pkg::*;

  localparam int PW = 2 * BYTE_W;

  ptr_op_t               op;
  logic [NUM_PAIRS-1:0]  wrap_vec;
  logic [NUM_PAIRS-1:0]  conflict_vec;

  assign op = ptr_op_t'(ptr_op);

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    reg_pair #(.BYTE_W(BYTE_W)) u_pair (
      .clock    (clock),
      .reset    (reset),
      .wen      (wen[2*p +: 2]),
      .din      (data_in[PW*p +: PW]),
      .ren      (ren[2*p +: 2]),
      .op       (op),
      .sel      (ptr_addr == 4'(p)),
      .dout     (data_out[PW*p +: PW]),
      .wrap     (wrap_vec[p]),
      .conflict (conflict_vec[p]),
      .zero     (pair_zero[p])
    );
  end

  // Only the addressed pair can pulse, so OR-reduction never merges two events.
  assign ptr_wrap     = |wrap_vec;
  assign ptr_conflict = |conflict_vec;

endmodule

// File: tb/tb_reg_file_bank.sv
module tb_reg_file_bank;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  wen = 32'h0;
  logic [255:0] data_in = 256'h0;
  logic [31:0]  ren = 32'h0;
  logic [255:0] data_out;
  logic [1:0]   ptr_op = 2'b00;
  logic [3:0]   ptr_addr = 4'h0;
  logic         ptr_wrap;
  logic         ptr_conflict;
  logic [15:0]  pair_zero;

  int checks = 0;
  int passes = 0;
  logic en = 1'b0;

  reg_file_bank dut (
    .clock(clock), .reset(reset), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(data_out), .ptr_op(ptr_op), .ptr_addr(ptr_addr),
    .ptr_wrap(ptr_wrap), .ptr_conflict(ptr_conflict), .pair_zero(pair_zero)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [15:0] m_pair [16];
  logic [15:0] m_zero;
  logic        m_wrap;
  logic        m_conf;

  function automatic logic [15:0] next_val(input logic [15:0] v, input logic [1:0] w,
                                           input logic [15:0] d, input logic [1:0] op);
    logic [15:0] r;
    r = v;
    if (w != 2'b00) begin
      if (w[0]) r[7:0]  = d[7:0];
      if (w[1]) r[15:8] = d[15:8];
    end else if (op == 2'd1) begin
      r = 16'((32'(v) + 1) % 65536);
    end else if (op == 2'd2) begin
      r = 16'((32'(v) + 65535) % 65536);
    end
    return r;
  endfunction

  function automatic logic got_wrap(input logic [15:0] v, input logic [1:0] w, input logic [1:0] op);
    return (w == 2'b00) && ((op == 2'd1 && v == 16'hFFFF) || (op == 2'd2 && v == 16'h0000));
  endfunction

  function automatic logic got_conf(input logic [1:0] w, input logic [1:0] op);
    return (w != 2'b00) && (op == 2'd1 || op == 2'd2);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 16; p++) m_pair[p] <= 16'h0000;
      m_zero <= 16'hFFFF;
      m_wrap <= 1'b0;
      m_conf <= 1'b0;
    end else begin
      for (int p = 0; p < 16; p++) begin
        m_zero[p] <= (m_pair[p] == 16'h0000);
        m_pair[p] <= next_val(m_pair[p], wen[2*p +: 2], data_in[16*p +: 16],
                              (p == int'(ptr_addr)) ? ptr_op : 2'b00);
      end
      m_wrap <= got_wrap(m_pair[ptr_addr], wen[2*ptr_addr +: 2], ptr_op);
      m_conf <= got_conf(wen[2*ptr_addr +: 2], ptr_op);
    end
  end

  function automatic logic [255:0] exp_dout();
    logic [255:0] r;
    r = 256'h0;
    for (int b = 0; b < 32; b++) begin
      if (!reset && ren[b]) r[8*b +: 8] = 8'((m_pair[b / 2] >> (8 * (b % 2))) & 16'h00FF);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compare process: every falling edge, DUT versus model.
  always @(negedge clock) begin
    if (en) begin
      chk("data_out", data_out, exp_dout());
      chk("ptr_wrap", 256'(ptr_wrap), 256'(m_wrap));
      chk("ptr_conflict", 256'(ptr_conflict), 256'(m_conf));
      chk("pair_zero", 256'(pair_zero), 256'(m_zero));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [255:0] put(input int p, input logic [15:0] v);
    logic [255:0] r;
    r = 256'h0;
    r[16*p +: 16] = v;
    return r;
  endfunction

  task automatic cyc(input logic [31:0] w, input logic [255:0] d, input logic [31:0] r,
                     input logic [1:0] op, input logic [3:0] a);
    @(negedge clock);
    #1;
    wen = w; data_in = d; ren = r; ptr_op = op; ptr_addr = a;
    @(posedge clock);
    #1;
  endtask

  logic [255:0] e;

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("reset data_out", data_out, 256'h0);
    chk("reset pair_zero", 256'(pair_zero), 256'(16'hFFFF));
    chk("reset ptr_wrap", 256'(ptr_wrap), 256'h0);
    chk("reset ptr_conflict", 256'(ptr_conflict), 256'h0);
    en = 1'b1;
    // ren high during reset must still read zero
    cyc(32'hFFFF_FFFF, {16{16'hA5A5}}, 32'hFFFF_FFFF, 2'b01, 4'h0);
    chk("reset gates writes", data_out, 256'h0);
    @(negedge clock); #1; reset = 1'b0; wen = 32'h0; ptr_op = 2'b00;

    // Byte write with same-cycle read-back
    cyc(32'h0000_0003, put(0, 16'hBEEF), 32'h3, 2'b00, 4'h0);
    chk("raw pair0", 256'(data_out[15:0]), 256'(16'hBEEF));
    cyc(32'h0, 256'h0, 32'h3, 2'b00, 4'h0);
    chk("pair_zero0 cleared", 256'(pair_zero[0]), 256'h0);

    // Increment carries into high byte
    cyc(32'h0000_0C00, put(5, 16'h12FF), 32'h0, 2'b00, 4'h0);
    cyc(32'h0, 256'h0, 32'h0000_0800, 2'b01, 4'h5);
    e = 256'h0; e[95:88] = 8'h13;
    chk("inc carry high byte only", data_out, e);
    // Decrement borrows back, reserved op is a no-op
    cyc(32'h0, 256'h0, 32'h0000_0C00, 2'b10, 4'h5);
    chk("dec borrow", 256'(data_out[95:80]), 256'(16'h12FF));
    cyc(32'h0, 256'h0, 32'h0000_0C00, 2'b11, 4'h5);
    chk("reserved op", 256'(data_out[95:80]), 256'(16'h12FF));

    // Back-to-back increments
    cyc(32'h0, 256'h0, 32'h3, 2'b01, 4'h0);
    cyc(32'h0, 256'h0, 32'h3, 2'b01, 4'h0);
    cyc(32'h0, 256'h0, 32'h3, 2'b01, 4'h0);
    chk("back-to-back inc", 256'(data_out[15:0]), 256'(16'hBEF2));

    // Wrap both ways
    cyc(32'h0000_00C0, put(3, 16'hFFFF), 32'hFFFF_FFFF, 2'b00, 4'h0);
    cyc(32'h0, 256'h0, 32'hFFFF_FFFF, 2'b01, 4'h3);
    chk("inc wrap value", 256'(data_out[63:48]), 256'h0);
    chk("inc wrap pulse", 256'(ptr_wrap), 256'h1);
    cyc(32'h0, 256'h0, 32'hFFFF_FFFF, 2'b00, 4'h3);
    chk("wrap one cycle", 256'(ptr_wrap), 256'h0);
    chk("pair_zero3 set", 256'(pair_zero[3]), 256'h1);
    cyc(32'h0, 256'h0, 32'hFFFF_FFFF, 2'b10, 4'h3);
    chk("dec wrap value", 256'(data_out[63:48]), 256'(16'hFFFF));
    chk("dec wrap pulse", 256'(ptr_wrap), 256'h1);

    // Conflict: write wins, pointer op dropped, other pair written concurrently
    cyc(32'h0000_C000, put(7, 16'h0010), 32'hFFFF_FFFF, 2'b00, 4'h0);
    cyc(32'h0003_4000, put(7, 16'h00AA) | put(8, 16'h1234), 32'hFFFF_FFFF, 2'b10, 4'h7);
    chk("conflict pair7", 256'(data_out[127:112]), 256'(16'h00AA));
    chk("conflict pair8", 256'(data_out[143:128]), 256'(16'h1234));
    chk("conflict pulse", 256'(ptr_conflict), 256'h1);
    chk("conflict no wrap", 256'(ptr_wrap), 256'h0);
    cyc(32'h0, 256'h0, 32'hFFFF_FFFF, 2'b00, 4'h0);
    chk("conflict one cycle", 256'(ptr_conflict), 256'h0);

    // Mid-cycle reset discards a pending write
    cyc(32'hFFFF_FFFF, {16{16'h5A5A}}, 32'hFFFF_FFFF, 2'b00, 4'h0);
    chk("load all", data_out, {16{16'h5A5A}});
    @(negedge clock); #1;
    wen = 32'hFFFF_FFFF; data_in = {16{16'h1111}}; ptr_op = 2'b01; ptr_addr = 4'h2;
    #2 reset = 1'b1;
    #1;
    chk("async reset data_out", data_out, 256'h0);
    chk("async reset pair_zero", 256'(pair_zero), 256'(16'hFFFF));
    @(negedge clock); #1;
    reset = 1'b0; wen = 32'h0; ptr_op = 2'b00;
    cyc(32'h0, 256'h0, 32'hFFFF_FFFF, 2'b00, 4'h0);
    chk("pending write lost", data_out, 256'h0);
    chk("pair_zero after reset", 256'(pair_zero), 256'(16'hFFFF));

    @(negedge clock); #1;
    en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
